// File: rtl/post_cov_semipar_if.sv
// rtl/post_cov_semipar_if.sv - start/busy/done bus of the 2x2 posterior covariance stage
// Ports (as interface members):
//   start                 request, driven by the master
//   h00..h11, k00..k11    H and K matrices, signed Q(N-FRAC).FRAC
//   pp00..pp11            prior covariance, same format
//   busy, done            status, driven by the slave
//   P_POST00..P_POST11    posterior covariance results, same format
// Modports: master (requester side), slave (post_cov_semipar side).
interface post_cov_semipar_if #(
    parameter int N = 20
);
    logic                start;
    logic signed [N-1:0] h00, h01, h10, h11;
    logic signed [N-1:0] k00, k01, k10, k11;
    logic signed [N-1:0] pp00, pp01, pp10, pp11;
    logic                busy;
    logic                done;
    logic signed [N-1:0] P_POST00, P_POST01, P_POST10, P_POST11;

    modport master (
        output start,
        output h00, h01, h10, h11,
        output k00, k01, k10, k11,
        output pp00, pp01, pp10, pp11,
        input  busy, done,
        input  P_POST00, P_POST01, P_POST10, P_POST11
    );

    modport slave (
        input  start,
        input  h00, h01, h10, h11,
        input  k00, k01, k10, k11,
        input  pp00, pp01, pp10, pp11,
        output busy, done,
        output P_POST00, P_POST01, P_POST10, P_POST11
    );
endinterface

// File: rtl/post_cov_semipar.sv
// rtl/post_cov_semipar.sv - 2x2 posterior covariance P_PRIOR - K*(H*P_PRIOR), 4 shared multipliers
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   post_cov_semipar_if.slave: start/busy/done handshake, H, K, P_PRIOR in, P_POST out
// Parameters: N data width, FRAC fractional bits (the interface N must match).
// A request is accepted on an idle edge E0 and the result lands on E7 with a
// one-cycle done pulse; the four multipliers are reused on four load steps.
module post_cov_semipar #(
    parameter int N    = 20,
    parameter int FRAC = 10
) (
    input  logic              clk,
    input  logic              rst,
    post_cov_semipar_if.slave bus
);
    localparam int W = 2 * N;

    typedef enum logic [2:0] {
        IDLE, PH1, PH2, PH3, PH4, PH5, PH6, PH7
    } phase_t;

    phase_t phase;

    // Captured operands: index 0..3 = element 00, 01, 10, 11.
    logic signed [N-1:0] c_h  [4];
    logic signed [N-1:0] c_k  [4];
    logic signed [N-1:0] c_pp [4];

    // Multiplier operand registers and intermediate M = H*P_PRIOR.
    logic signed [N-1:0] op_a [4];
    logic signed [N-1:0] op_b [4];
    logic signed [N-1:0] m00, m01, m10, m11;

    // Truncated first-column results held until the second column finishes,
    // so the visible outputs only ever change at E7.
    logic signed [N-1:0] hold00, hold10;

    logic signed [N-1:0] post00, post01, post10, post11;
    logic                busy_r, done_r;

    logic signed [W-1:0] prod [4];
    logic signed [W-1:0] sum01, sum23;

    function automatic logic signed [W-1:0] sext(input logic signed [N-1:0] v);
        return {{N{v[N-1]}}, v};
    endfunction

    // Floor truncation back to N bits: drop FRAC low bits, wrap the top.
    function automatic logic signed [N-1:0] trunc(input logic signed [W-1:0] x);
        return x[FRAC+N-1:FRAC];
    endfunction

    function automatic logic signed [W-1:0] pp2n(input logic signed [N-1:0] v);
        return sext(v) <<< FRAC;
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            prod[i] = sext(op_a[i]) * sext(op_b[i]);
        end
        sum01 = prod[0] + prod[1];
        sum23 = prod[2] + prod[3];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                c_h[i]  <= '0;
                c_k[i]  <= '0;
                c_pp[i] <= '0;
                op_a[i] <= '0;
                op_b[i] <= '0;
            end
            m00    <= '0;
            m01    <= '0;
            m10    <= '0;
            m11    <= '0;
            hold00 <= '0;
            hold10 <= '0;
            post00 <= '0;
            post01 <= '0;
            post10 <= '0;
            post11 <= '0;
        end else begin
            done_r <= 1'b0;
            case (phase)
                IDLE: begin
                    if (bus.start) begin
                        c_h[0]  <= bus.h00;  c_h[1]  <= bus.h01;
                        c_h[2]  <= bus.h10;  c_h[3]  <= bus.h11;
                        c_k[0]  <= bus.k00;  c_k[1]  <= bus.k01;
                        c_k[2]  <= bus.k10;  c_k[3]  <= bus.k11;
                        c_pp[0] <= bus.pp00; c_pp[1] <= bus.pp01;
                        c_pp[2] <= bus.pp10; c_pp[3] <= bus.pp11;
                        // Column 0 of H*P_PRIOR straight from the ports.
                        op_a[0] <= bus.h00;  op_b[0] <= bus.pp00;
                        op_a[1] <= bus.h01;  op_b[1] <= bus.pp10;
                        op_a[2] <= bus.h10;  op_b[2] <= bus.pp00;
                        op_a[3] <= bus.h11;  op_b[3] <= bus.pp10;
                        busy_r  <= 1'b1;
                        phase   <= PH1;
                    end
                end
                PH1: begin
                    m00   <= trunc(sum01);
                    m10   <= trunc(sum23);
                    phase <= PH2;
                end
                PH2: begin
                    // Column 1 of H*P_PRIOR.
                    for (int i = 0; i < 4; i++) begin
                        op_a[i] <= c_h[i];
                    end
                    op_b[0] <= c_pp[1];
                    op_b[1] <= c_pp[3];
                    op_b[2] <= c_pp[1];
                    op_b[3] <= c_pp[3];
                    phase   <= PH3;
                end
                PH3: begin
                    m01   <= trunc(sum01);
                    m11   <= trunc(sum23);
                    phase <= PH4;
                end
                PH4: begin
                    for (int i = 0; i < 4; i++) begin
                        op_a[i] <= c_k[i];
                    end
                    op_b[0] <= m00;
                    op_b[1] <= m10;
                    op_b[2] <= m00;
                    op_b[3] <= m10;
                    phase   <= PH5;
                end
                PH5: begin
                    // Subtraction stays in the 2N domain so K*M is not rounded
                    // before it is removed from P_PRIOR.
                    hold00 <= trunc(pp2n(c_pp[0]) - sum01);
                    hold10 <= trunc(pp2n(c_pp[2]) - sum23);
                    phase  <= PH6;
                end
                PH6: begin
                    for (int i = 0; i < 4; i++) begin
                        op_a[i] <= c_k[i];
                    end
                    op_b[0] <= m01;
                    op_b[1] <= m11;
                    op_b[2] <= m01;
                    op_b[3] <= m11;
                    phase   <= PH7;
                end
                PH7: begin
                    post00 <= hold00;
                    post10 <= hold10;
                    post01 <= trunc(pp2n(c_pp[1]) - sum01);
                    post11 <= trunc(pp2n(c_pp[3]) - sum23);
                    done_r <= 1'b1;
                    busy_r <= 1'b0;
                    phase  <= IDLE;
                end
                default: phase <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.P_POST00 = post00;
    assign bus.P_POST01 = post01;
    assign bus.P_POST10 = post10;
    assign bus.P_POST11 = post11;
endmodule

// File: tb/tb_post_cov_semipar.sv
// tb/tb_post_cov_semipar.sv - self-checking bench for post_cov_semipar
module tb_post_cov_semipar;
    localparam int N    = 20;
    localparam int FRAC = 10;

    typedef logic signed [63:0] val_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    post_cov_semipar_if #(.N(N)) bus ();

    post_cov_semipar #(.N(N), .FRAC(FRAC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Stimulus matrices, row-major: index 0=00, 1=01, 2=10, 3=11.
    longint sh [4];
    longint sk [4];
    longint sp [4];
    longint exp_next [4];
    longint exp_hold [4];

    task automatic check(input string tag, input val_t obs, input val_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sx(input longint v, input int w);
        longint t;
        t = v <<< (64 - w);
        return t >>> (64 - w);
    endfunction

    function automatic longint tr(input longint x);
        return sx(sx(x, 2 * N) >>> FRAC, N);
    endfunction

    // Reference: M = T(H*P), P_POST = T(P*2^FRAC - K*M) as plain matrix math.
    task automatic model();
        longint m [4];
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                m[2*i+j] = tr(sh[2*i] * sp[j] + sh[2*i+1] * sp[2+j]);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                exp_next[2*i+j] = tr((sp[2*i+j] <<< FRAC) - (sk[2*i] * m[j] + sk[2*i+1] * m[2+j]));
    endtask

    task automatic drive();
        bus.h00  = N'(sh[0]); bus.h01  = N'(sh[1]); bus.h10  = N'(sh[2]); bus.h11  = N'(sh[3]);
        bus.k00  = N'(sk[0]); bus.k01  = N'(sk[1]); bus.k10  = N'(sk[2]); bus.k11  = N'(sk[3]);
        bus.pp00 = N'(sp[0]); bus.pp01 = N'(sp[1]); bus.pp10 = N'(sp[2]); bus.pp11 = N'(sp[3]);
    endtask

    task automatic set_mats(input longint h0, h1, h2, h3, k0, k1, k2, k3, p0, p1, p2, p3);
        sh[0] = h0; sh[1] = h1; sh[2] = h2; sh[3] = h3;
        sk[0] = k0; sk[1] = k1; sk[2] = k2; sk[3] = k3;
        sp[0] = p0; sp[1] = p1; sp[2] = p2; sp[3] = p3;
    endtask

    function automatic longint rnd(input bit wide);
        if (wide) return sx(longint'($urandom) & 64'hFFFFF, N);
        return longint'($urandom_range(0, 8191)) - 4096;
    endfunction

    task automatic check_out(input string tag, input longint e0, e1, e2, e3);
        check({tag, ".p00"}, bus.P_POST00, e0);
        check({tag, ".p01"}, bus.P_POST01, e1);
        check({tag, ".p10"}, bus.P_POST10, e2);
        check({tag, ".p11"}, bus.P_POST11, e3);
    endtask

    // Drives the current matrices, computes the expectation and crosses E0.
    task automatic start_op(input string tag);
        model();
        drive();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, ".busy_e0"}, bus.busy, 1);
        check({tag, ".done_e0"}, bus.done, 0);
    endtask

    // Waits for done (bounded); optionally scrambles inputs and re-pulses start mid-run.
    task automatic wait_done(input string tag, input bit mess);
        int lat;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = c;
                break;
            end
            check({tag, ".busy_run"}, bus.busy, 1);
            check({tag, ".hold_p00"}, bus.P_POST00, exp_hold[0]);
            check({tag, ".hold_p11"}, bus.P_POST11, exp_hold[3]);
            if (mess && c == 2) begin
                for (int i = 0; i < 4; i++) begin
                    sh[i] = rnd(1); sk[i] = rnd(1); sp[i] = rnd(1);
                end
                drive();
                bus.start = 1'b1;
            end
            if (mess && c == 4) bus.start = 1'b0;
        end
        check({tag, ".latency"}, lat, 7);
        check({tag, ".busy_done"}, bus.busy, 0);
        check_out(tag, exp_next[0], exp_next[1], exp_next[2], exp_next[3]);
        for (int i = 0; i < 4; i++) exp_hold[i] = exp_next[i];
    endtask

    task automatic idle_check(input string tag, input int n);
        int dones;
        dones = 0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        check({tag, ".no_done"}, dones, 0);
        check({tag, ".idle_busy"}, bus.busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        set_mats(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive();
        for (int i = 0; i < 4; i++) exp_hold[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.busy", bus.busy, 0);
        check("reset.done", bus.done, 0);
        check_out("reset", 0, 0, 0, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Identity: K=0, H=I
        set_mats(1024, 0, 0, 1024, 0, 0, 0, 0, 2048, 1024, 1024, 3072);
        start_op("ident");
        wait_done("ident", 0);
        check_out("ident_lit", 2048, 1024, 1024, 3072);
        idle_check("ident", 1);

        // Scaled gain
        set_mats(1024, 0, 0, 1024, 512, 0, 0, 256, 2048, 1024, 1024, 3072);
        start_op("scaled");
        wait_done("scaled", 0);
        check_out("scaled_lit", 1024, 512, 768, 2304);

        // Floor truncation
        set_mats(1024, 0, 0, 1024, 1, 0, 0, 1, 3, 0, 0, 3);
        start_op("floor");
        wait_done("floor", 0);
        check_out("floor_lit", 2, 0, 0, 2);

        // Negatives
        set_mats(1024, 0, 0, 1024, 1024, 0, 0, 1024, -1024, -512, -512, -1024);
        start_op("neg_a");
        wait_done("neg_a", 0);
        check_out("neg_a_lit", 0, 0, 0, 0);
        set_mats(1024, 0, 0, 1024, -1024, 0, 0, -1024, -1024, -512, -512, -1024);
        start_op("neg_b");
        wait_done("neg_b", 0);
        check_out("neg_b_lit", -2048, -1024, -1024, -2048);
        idle_check("neg_b", 2);

        // start and input changes during busy are ignored
        for (int i = 0; i < 4; i++) begin
            sh[i] = rnd(0); sk[i] = rnd(0); sp[i] = rnd(0);
        end
        start_op("ignore");
        wait_done("ignore", 1);
        idle_check("ignore", 3);

        // Back-to-back: start on the done cycle
        for (int i = 0; i < 4; i++) begin
            sh[i] = rnd(0); sk[i] = rnd(0); sp[i] = rnd(0);
        end
        start_op("b2b_1");
        wait_done("b2b_1", 0);
        for (int i = 0; i < 4; i++) begin
            sh[i] = rnd(1); sk[i] = rnd(1); sp[i] = rnd(1);
        end
        start_op("b2b_2");
        wait_done("b2b_2", 0);
        idle_check("b2b_2", 3);

        // Asynchronous reset at E3 aborts the run
        for (int i = 0; i < 4; i++) begin
            sh[i] = rnd(0); sk[i] = rnd(0); sp[i] = rnd(0);
        end
        start_op("abort");
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort.busy", bus.busy, 0);
        check("abort.done", bus.done, 0);
        check_out("abort", 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) exp_hold[i] = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_check("abort", 10);
        check_out("abort_after", 0, 0, 0, 0);
        start_op("recover");
        wait_done("recover", 0);

        // Randomized runs, alternating full-range (wrapping) and moderate values
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < 4; i++) begin
                sh[i] = rnd(r[0]); sk[i] = rnd(r[0]); sp[i] = rnd(r[0]);
            end
            start_op("rand");
            wait_done("rand", 0);
            if (r[1]) idle_check("rand", 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
